// File: rtl/csr_timer_intc_if.sv
// CSR access bus between the core CSR file (master) and the timer/interrupt unit (slave).
// csr_num is used for both the combinational read and the write.
interface csr_timer_intc_if;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        csr_hit;

  modport master (output csr_num, csr_we, csr_wmask, csr_wvalue,
                  input  csr_rvalue, csr_hit);
  modport slave  (input  csr_num, csr_we, csr_wmask, csr_wvalue,
                  output csr_rvalue, csr_hit);
endinterface

// File: rtl/csr_timer_intc.sv
// Timer/interrupt CSR unit: NUM_TIMERS countdown channels, synchronised HW interrupts,
// SW interrupt bits, interrupt-enable mask, and a 64-bit stable counter.
module csr_timer_ch #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tcfg_we,
  input  logic             ticlr_we,
  input  logic [CNT_W-1:0] wmask,
  input  logic [CNT_W-1:0] wvalue,
  output logic [31:0]      tcfg_rd,
  output logic [31:0]      tval_rd,
  output logic             pend_o
);
  localparam int IV_W = CNT_W - 2;

  logic             en_q, en_d, per_q, per_d, pend_q, pend_d;
  logic [IV_W-1:0]  iv_q, iv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cfg_old, cfg_new;

  assign cfg_old = {iv_q, per_q, en_q};
  assign cfg_new = (wmask & wvalue) | (~wmask & cfg_old);

  always_comb begin
    {iv_d, per_d, en_d} = tcfg_we ? cfg_new : cfg_old;
    cnt_d = cnt_q;
    // A config write owns the counter this cycle: reload if enabled, otherwise freeze.
    if (tcfg_we) begin
      if (en_d) cnt_d = {iv_d, 2'b00};
    end else if (en_q && cnt_q != '1) begin
      if (cnt_q == '0 && per_q) cnt_d = {iv_q, 2'b00};
      else                      cnt_d = cnt_q - CNT_W'(1);
    end
    pend_d = pend_q;
    if (en_q && cnt_q == '0)          pend_d = 1'b1;
    else if (ticlr_we && wmask[0] && wvalue[0]) pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= 1'b0;
      per_q  <= 1'b0;
      iv_q   <= '0;
      cnt_q  <= '1;
      pend_q <= 1'b0;
    end else begin
      en_q   <= en_d;
      per_q  <= per_d;
      iv_q   <= iv_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign tcfg_rd = 32'(cfg_old);
  assign tval_rd = 32'(cnt_q);
  assign pend_o  = pend_q;
endmodule

module csr_timer_intc #(
  parameter int          NUM_TIMERS = 1,
  parameter int          CNT_W      = 32,
  parameter int          HW_INT_NUM = 8,
  parameter logic [13:0] IEN_ADDR   = 14'h004,
  parameter logic [13:0] ISTAT_ADDR = 14'h005,
  parameter logic [13:0] TID_ADDR   = 14'h040,
  parameter logic [13:0] TMR_BASE   = 14'h041
) (
  input  logic                                clk,
  input  logic                                reset,
  csr_timer_intc_if.slave                     csr,
  input  logic [HW_INT_NUM-1:0]               hw_int_in,
  input  logic                                crmd_ie,
  output logic [2+HW_INT_NUM+NUM_TIMERS-1:0]  int_vec,
  output logic                                has_int,
  output logic [4:0]                          int_id,
  output logic [63:0]                         stable_cnt
);
  localparam int INT_W = 2 + HW_INT_NUM + NUM_TIMERS;

  logic [INT_W-1:0]                 ien_q, ien_d, int_act;
  logic [1:0]                       sw_q, sw_d;
  logic [31:0]                      tid_q, tid_d;
  logic [HW_INT_NUM-1:0]            sync1_q, sync2_q;
  logic [63:0]                      scnt_q;
  logic [NUM_TIMERS-1:0]            tcfg_we, ticlr_we, pend;
  logic [NUM_TIMERS-1:0][31:0]      tcfg_rd, tval_rd;

  for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_ch
    assign tcfg_we[n]  = csr.csr_we && (csr.csr_num == TMR_BASE + 14'(8*n));
    assign ticlr_we[n] = csr.csr_we && (csr.csr_num == TMR_BASE + 14'(8*n + 3));
    csr_timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tcfg_we  (tcfg_we[n]),
      .ticlr_we (ticlr_we[n]),
      .wmask    (csr.csr_wmask[CNT_W-1:0]),
      .wvalue   (csr.csr_wvalue[CNT_W-1:0]),
      .tcfg_rd  (tcfg_rd[n]),
      .tval_rd  (tval_rd[n]),
      .pend_o   (pend[n])
    );
  end

  always_comb begin
    ien_d = ien_q;
    sw_d  = sw_q;
    tid_d = tid_q;
    if (csr.csr_we) begin
      if (csr.csr_num == IEN_ADDR)
        ien_d = (csr.csr_wmask[INT_W-1:0] & csr.csr_wvalue[INT_W-1:0]) | (~csr.csr_wmask[INT_W-1:0] & ien_q);
      if (csr.csr_num == ISTAT_ADDR)
        sw_d = (csr.csr_wmask[1:0] & csr.csr_wvalue[1:0]) | (~csr.csr_wmask[1:0] & sw_q);
      if (csr.csr_num == TID_ADDR)
        tid_d = (csr.csr_wmask & csr.csr_wvalue) | (~csr.csr_wmask & tid_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ien_q   <= '0;
      sw_q    <= '0;
      tid_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      scnt_q  <= '0;
    end else begin
      ien_q   <= ien_d;
      sw_q    <= sw_d;
      tid_q   <= tid_d;
      sync1_q <= hw_int_in;
      sync2_q <= sync1_q;
      scnt_q  <= scnt_q + 64'd1;
    end
  end

  assign int_vec    = {pend, sync2_q, sw_q};
  assign int_act    = int_vec & ien_q;
  assign has_int    = (|int_act) & crmd_ie;
  assign stable_cnt = scnt_q;

  always_comb begin
    int_id = '0;
    for (int i = 0; i < INT_W; i++)
      if (int_act[i]) int_id = 5'(i);
  end

  // Read path is purely combinational on csr_num; TICLR decodes as a hit but reads 0.
  always_comb begin
    csr.csr_rvalue = '0;
    csr.csr_hit    = 1'b0;
    if (csr.csr_num == IEN_ADDR)   begin csr.csr_hit = 1'b1; csr.csr_rvalue = 32'(ien_q);   end
    if (csr.csr_num == ISTAT_ADDR) begin csr.csr_hit = 1'b1; csr.csr_rvalue = 32'(int_vec); end
    if (csr.csr_num == TID_ADDR)   begin csr.csr_hit = 1'b1; csr.csr_rvalue = tid_q;        end
    for (int n = 0; n < NUM_TIMERS; n++) begin
      if (csr.csr_num == TMR_BASE + 14'(8*n))     begin csr.csr_hit = 1'b1; csr.csr_rvalue = tcfg_rd[n]; end
      if (csr.csr_num == TMR_BASE + 14'(8*n + 1)) begin csr.csr_hit = 1'b1; csr.csr_rvalue = tval_rd[n]; end
      if (csr.csr_num == TMR_BASE + 14'(8*n + 3)) csr.csr_hit = 1'b1;
    end
  end
endmodule

// File: tb/tb_csr_timer_intc.sv
// Random + directed bench for csr_timer_intc with a queue scoreboard against a
// behavioural model of the timer/interrupt rules.
module tb_csr_timer_intc;
  localparam int NT = 4, CW = 16, HW = 8, IW = 2 + HW + NT;
  localparam logic [13:0] IEN_A = 14'h004, ISTAT_A = 14'h005, TID_A = 14'h040, TB_A = 14'h041;
  localparam int unsigned ONES = (1 << CW) - 1;
  localparam int unsigned IWM  = (1 << IW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [HW-1:0] hw_in;
  logic ie;
  logic [IW-1:0] int_vec;
  logic has_int;
  logic [4:0] int_id;
  logic [63:0] scnt;
  always #5 clk = ~clk;

  csr_timer_intc_if bus();

  csr_timer_intc #(.NUM_TIMERS(NT), .CNT_W(CW), .HW_INT_NUM(HW)) dut (
    .clk(clk), .reset(reset), .csr(bus), .hw_int_in(hw_in), .crmd_ie(ie),
    .int_vec(int_vec), .has_int(has_int), .int_id(int_id), .stable_cnt(scnt)
  );

  typedef struct {
    logic [13:0]   num;
    logic [31:0]   rv;
    logic          hit;
    logic [IW-1:0] iv;
    logic          hi;
    logic [4:0]    id;
    logic [63:0]   sc;
  } exp_t;
  exp_t expq[$];

  int checks = 0, failures = 0;

  // Reference model state
  int unsigned m_ien, m_sw, m_tid;
  int unsigned m_iv[NT], m_cnt[NT];
  bit          m_en[NT], m_per[NT], m_pend[NT];
  logic [HW-1:0] m_h1, m_h2;
  longint unsigned m_sc;

  logic nxt_rst;
  logic [HW-1:0] nxt_hw;
  logic nxt_ie;

  function automatic int unsigned merge(int unsigned o, int unsigned m, int unsigned v);
    return (m & v) | (~m & o);
  endfunction

  function automatic void model_step();
    if (reset) begin
      m_ien = 0; m_sw = 0; m_tid = 0; m_h1 = '0; m_h2 = '0; m_sc = 0;
      for (int n = 0; n < NT; n++) begin
        m_en[n] = 0; m_per[n] = 0; m_iv[n] = 0; m_cnt[n] = ONES; m_pend[n] = 0;
      end
      return;
    end
    m_sc++;
    m_h2 = m_h1;
    m_h1 = hw_in;
    for (int n = 0; n < NT; n++) begin
      bit tcfg, clr, hit0;
      int unsigned ncfg;
      tcfg = bus.csr_we && bus.csr_num == TB_A + 14'(8*n);
      clr  = bus.csr_we && bus.csr_num == TB_A + 14'(8*n + 3) && bus.csr_wmask[0] && bus.csr_wvalue[0];
      hit0 = m_en[n] && m_cnt[n] == 0;
      ncfg = merge((m_iv[n] << 2) | (int'(m_per[n]) << 1) | int'(m_en[n]), bus.csr_wmask, bus.csr_wvalue) & ONES;
      if (tcfg) begin
        m_en[n] = ncfg[0]; m_per[n] = ncfg[1]; m_iv[n] = ncfg >> 2;
        if (m_en[n]) m_cnt[n] = m_iv[n] * 4;
      end else if (m_en[n] && m_cnt[n] != ONES) begin
        if (m_cnt[n] == 0) m_cnt[n] = m_per[n] ? m_iv[n] * 4 : ONES;
        else               m_cnt[n] = m_cnt[n] - 1;
      end
      m_pend[n] = hit0 ? 1'b1 : (clr ? 1'b0 : m_pend[n]);
    end
    if (bus.csr_we && bus.csr_num == IEN_A)   m_ien = merge(m_ien, bus.csr_wmask, bus.csr_wvalue) & IWM;
    if (bus.csr_we && bus.csr_num == ISTAT_A) m_sw  = merge(m_sw, bus.csr_wmask, bus.csr_wvalue) & 3;
    if (bus.csr_we && bus.csr_num == TID_A)   m_tid = merge(m_tid, bus.csr_wmask, bus.csr_wvalue);
  endfunction

  function automatic int unsigned model_ivec();
    int unsigned v;
    v = m_sw | (int'(m_h2) << 2);
    for (int n = 0; n < NT; n++) if (m_pend[n]) v |= 1 << (2 + HW + n);
    return v;
  endfunction

  function automatic exp_t model_expect(logic [13:0] num, logic cie);
    exp_t e;
    int unsigned act;
    e.num = num; e.rv = 0; e.hit = 0;
    act = model_ivec() & m_ien;
    e.iv = IW'(model_ivec());
    e.hi = (act != 0) && cie;
    e.id = 0;
    for (int i = 0; i < IW; i++) if (act[i]) e.id = 5'(i);
    e.sc = m_sc;
    if (num == IEN_A)   begin e.hit = 1; e.rv = m_ien; end
    if (num == ISTAT_A) begin e.hit = 1; e.rv = model_ivec(); end
    if (num == TID_A)   begin e.hit = 1; e.rv = m_tid; end
    for (int n = 0; n < NT; n++) begin
      if (num == TB_A + 14'(8*n))     begin e.hit = 1; e.rv = (m_iv[n] << 2) | (int'(m_per[n]) << 1) | int'(m_en[n]); end
      if (num == TB_A + 14'(8*n + 1)) begin e.hit = 1; e.rv = m_cnt[n]; end
      if (num == TB_A + 14'(8*n + 3)) e.hit = 1;
    end
    return e;
  endfunction

  // One clock: model consumes the inputs the DUT just sampled, then new inputs are driven.
  task automatic cyc(input logic [13:0] num, input bit we, input logic [31:0] wm, input logic [31:0] wv);
    @(posedge clk);
    model_step();
    #1;
    reset = nxt_rst; hw_in = nxt_hw; ie = nxt_ie;
    bus.csr_num = num; bus.csr_we = we; bus.csr_wmask = wm; bus.csr_wvalue = wv;
    if (!reset) expq.push_back(model_expect(num, ie));
  endtask

  task automatic rd(input logic [13:0] num);
    cyc(num, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] wm, input logic [31:0] wv);
    cyc(num, 1'b1, wm, wv);
  endtask

  function automatic void chk(string nm, logic [13:0] num, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s num=%h actual=%h required=%h t=%0t", nm, num, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("rvalue",  e.num, 64'(bus.csr_rvalue), 64'(e.rv));
      chk("hit",     e.num, 64'(bus.csr_hit),    64'(e.hit));
      chk("int_vec", e.num, 64'(int_vec),        64'(e.iv));
      chk("has_int", e.num, 64'(has_int),        64'(e.hi));
      chk("int_id",  e.num, 64'(int_id),         64'(e.id));
      chk("stable",  e.num, scnt,                e.sc);
    end
  end

  function automatic logic [13:0] tcfg(int n);  return TB_A + 14'(8*n);     endfunction
  function automatic logic [13:0] tval(int n);  return TB_A + 14'(8*n + 1); endfunction
  function automatic logic [13:0] ticlr(int n); return TB_A + 14'(8*n + 3); endfunction

  initial begin
    logic [13:0] a;
    reset = 1'b1; hw_in = '0; ie = 1'b0;
    bus.csr_num = '0; bus.csr_we = 1'b0; bus.csr_wmask = '0; bus.csr_wvalue = '0;
    nxt_rst = 1'b1; nxt_hw = '0; nxt_ie = 1'b0;
    rd(IEN_A); rd(IEN_A);
    nxt_rst = 1'b0;
    rd(IEN_A); rd(ISTAT_A); rd(TID_A);
    for (int n = 0; n < NT; n++) begin rd(tval(n)); rd(tcfg(n)); end

    // One-shot count down through zero to all-ones
    wr(tcfg(0), 32'hFFFF_FFFF, 32'h11);
    repeat (22) rd(tval(0));
    rd(ISTAT_A);
    wr(ticlr(0), 32'h1, 32'h1);
    rd(ISTAT_A);

    // Periodic with clears landing at various phases, including a hit-zero cycle
    wr(tcfg(0), 32'hFFFF_FFFF, 32'h0B);
    for (int i = 0; i < 30; i++)
      if (i % 4 == 3) wr(ticlr(0), 32'h1, 32'h1); else rd((i % 2) ? ISTAT_A : tval(0));
    wr(tcfg(0), 32'h1, 32'h0);
    wr(ticlr(0), 32'h1, 32'h1);

    // Interrupt gating through hw line 0
    wr(IEN_A, 32'hFFFF_FFFF, 32'h4);
    nxt_hw = 8'h01;
    repeat (3) rd(ISTAT_A);
    nxt_ie = 1'b1;
    repeat (3) rd(ISTAT_A);
    nxt_hw = 8'h00;
    repeat (4) rd(ISTAT_A);

    // Two channels pending together, everything enabled
    wr(tcfg(1), 32'hFFFF_FFFF, 32'h09);
    wr(tcfg(3), 32'hFFFF_FFFF, 32'h0D);
    wr(IEN_A, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (16) rd(ISTAT_A);
    rd(tcfg(3)); rd(TB_A + 14'd2); rd(14'h04A); rd(14'h04B);

    // Masked write: disable only, counter freezes and initval stays
    wr(tcfg(2), 32'hFFFF_FFFF, 32'h101);
    repeat (5) rd(tval(2));
    wr(tcfg(2), 32'h1, 32'h0);
    repeat (4) rd(tval(2));
    rd(tcfg(2));

    // Reset mid-count with a concurrent write that must be dropped
    wr(tcfg(0), 32'hFFFF_FFFF, 32'h3F1);
    repeat (5) rd(tval(0));
    nxt_rst = 1'b1;
    wr(tcfg(1), 32'hFFFF_FFFF, 32'h21);
    nxt_rst = 1'b0;
    wr(tcfg(1), 32'hFFFF_FFFF, 32'h21);
    rd(IEN_A); rd(ISTAT_A);
    for (int n = 0; n < NT; n++) rd(tval(n));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 4))
        0: a = IEN_A;
        1: a = ISTAT_A;
        2: a = TID_A;
        3: a = TB_A + 14'(8 * $urandom_range(0, NT - 1) + $urandom_range(0, 3));
        default: a = 14'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) nxt_hw = 8'($urandom);
      if ($urandom_range(0, 9) == 0) nxt_ie = 1'($urandom);
      if ($urandom_range(0, 3) == 0)
        wr(a, ($urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom), $urandom & ($urandom_range(0, 1) ? 32'hFF : 32'hFFFF_FFFF));
      else
        rd(a);
    end
    rd(ISTAT_A);
    repeat (3) @(posedge clk);
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
